fetch_queue: RTL and testbench

- Front end of the RV32I core. Issues word fetches to instruction memory, buffers the returned instructions in order, and delivers them one per cycle to the decoder with i_en/i_next_pc/i_instr/i_tag semantics.
- Owns the PC and the 4-bit instruction tag sequence.
- On a redirect from the branch unit, flushes buffered and in-flight fetches and restarts at the new PC.

---
 rtl/fetch_queue_pkg.sv | 6 +
 rtl/fq_fifo.sv | 49 ++++
 rtl/fetch_queue.sv | 94 +++++++++
 tb/tb_fetch_queue.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/fetch_queue_pkg.sv
// fetch_queue_pkg: shared state encoding and constants for the fetch front end
package fetch_queue_pkg;
  typedef enum logic {FQ_RUN = 1'b0, FQ_FLUSH = 1'b1} fq_state_e;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;
endpackage

// File: rtl/fq_fifo.sv
// fq_fifo: synchronous in-order instruction buffer with clear priority
module fq_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 64
) (
  input  logic                     i_clk,
  input  logic                     i_rstn,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     clear,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic pop_ok;
  assign empty = count == '0;
  assign full = count == (AW+1)'(DEPTH);
  assign pop_ok = pop && !empty;
  assign dout = mem[rd_ptr];
  // pointers and occupancy; clear wins over push/pop
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop_ok);
    end
  end
  // storage write, no reset needed on data
  always_ff @(posedge i_clk) begin
    if (push && !clear) mem[wr_ptr] <= din;
  end
  // the credit scheme upstream must never let a push land on a full buffer
  always_ff @(posedge i_clk) begin
    assert (!i_rstn || clear || !(push && full));
  end
endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: PC owner, credit-limited imem fetch, in-order delivery to the decoder
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int TAG_W = 4
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  output logic             o_imem_req,
  output logic [31:0]      o_imem_addr,
  input  logic             i_imem_gnt,
  input  logic             i_imem_rvalid,
  input  logic [31:0]      i_imem_rdata,
  input  logic             i_redirect,
  input  logic [31:0]      i_redirect_pc,
  input  logic             i_stall,
  output logic             o_en,
  output logic [31:0]      o_next_pc,
  output logic [31:0]      o_instr,
  output logic [TAG_W-1:0] o_tag
);
  localparam int CW = $clog2(DEPTH) + 1;
  fq_state_e state, state_n;
  logic [31:0] pc, resp_npc;
  logic [CW-1:0] outstanding, discard, count, outstanding_n, discard_n;
  logic [CW+1:0] inflight;
  logic [TAG_W-1:0] tag;
  logic [63:0] dout;
  logic empty, full, accept, disc_rv, push, pop;
  fq_fifo #(.DEPTH(DEPTH), .W(64)) u_fifo (
    .i_clk(i_clk),
    .i_rstn(i_rstn),
    .push(push),
    .pop(pop),
    .clear(i_redirect),
    .din({resp_npc, i_imem_rdata}),
    .dout(dout),
    .count(count),
    .empty(empty),
    .full(full)
  );
  // outstanding fetches are contiguous words ending just below pc, so the oldest one's address is recoverable
  assign resp_npc = pc - (32'(outstanding) << 2) + 32'd4;
  assign o_imem_addr = pc;
  // next-state, credit check and counter arithmetic
  always_comb begin
    inflight = (CW+2)'(count) + (CW+2)'(outstanding) + (CW+2)'(discard);
    o_imem_req = i_rstn && state == FQ_RUN && inflight < (CW+2)'(DEPTH);
    accept = o_imem_req && i_imem_gnt;
    disc_rv = i_imem_rvalid && discard != '0;
    push = i_imem_rvalid && !disc_rv && !i_redirect;
    pop = !empty && !i_stall && !i_redirect;
    outstanding_n = i_redirect ? '0 : outstanding + CW'(accept) - CW'(push);
    discard_n = i_redirect ? discard + outstanding + CW'(accept) - CW'(i_imem_rvalid) : discard - CW'(disc_rv);
    state_n = discard_n != '0 ? FQ_FLUSH : FQ_RUN;
  end
  // state register
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) state <= FQ_RUN;
    else state <= state_n;
  end
  // pc and fetch accounting
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      pc <= RESET_PC;
      outstanding <= '0;
      discard <= '0;
    end else begin
      pc <= i_redirect ? i_redirect_pc & WORD_MASK : accept ? pc + 32'd4 : pc;
      outstanding <= outstanding_n;
      discard <= discard_n;
    end
  end
  // decoder-facing registers; data holds when nothing is popped
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_en <= 1'b0;
      o_next_pc <= '0;
      o_instr <= '0;
      o_tag <= '0;
      tag <= '0;
    end else begin
      o_en <= pop;
      if (pop) begin
        o_next_pc <= dout[63:32];
        o_instr <= dout[31:0];
        o_tag <= tag;
        tag <= tag + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: randomized imem/decoder traffic checked against a queue-based model
module tb_fetch_queue;
  import fetch_queue_pkg::*;
  localparam int DEPTH = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int TAG_W = 4;
  logic i_clk, i_rstn, o_imem_req, i_imem_gnt, i_imem_rvalid, i_redirect, i_stall, o_en;
  logic [31:0] o_imem_addr, i_imem_rdata, i_redirect_pc, o_next_pc, o_instr;
  logic [TAG_W-1:0] o_tag;
  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC), .TAG_W(TAG_W)) dut (
    .i_clk(i_clk),
    .i_rstn(i_rstn),
    .o_imem_req(o_imem_req),
    .o_imem_addr(o_imem_addr),
    .i_imem_gnt(i_imem_gnt),
    .i_imem_rvalid(i_imem_rvalid),
    .i_imem_rdata(i_imem_rdata),
    .i_redirect(i_redirect),
    .i_redirect_pc(i_redirect_pc),
    .i_stall(i_stall),
    .o_en(o_en),
    .o_next_pc(o_next_pc),
    .o_instr(o_instr),
    .o_tag(o_tag)
  );
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;
  int errors = 0, checks = 0, cyc = 0, gnt_pct = 100, rv_pct = 100;
  int n_dut_gnt = 0, n_dut_en = 0;
  bit data_is_addr = 1'b0;
  logic [31:0] m_pc, m_npc, m_instr;
  logic [TAG_W-1:0] m_tag, m_tag_out;
  bit m_req, m_en;
  logic [31:0] q_npc[$], q_instr[$], f_addr[$], f_data[$];
  int f_ready[$];
  bit f_stale[$];
  task automatic reset_model();
    m_pc = RESET_PC; m_npc = '0; m_instr = '0; m_tag = '0; m_tag_out = '0;
    m_en = 1'b0; m_req = 1'b1;
    q_npc.delete(); q_instr.delete(); f_addr.delete(); f_data.delete(); f_ready.delete(); f_stale.delete();
  endtask
  task automatic idle_inputs();
    i_imem_gnt = 1'b0; i_imem_rvalid = 1'b0; i_imem_rdata = NOP_INSTR;
    i_redirect = 1'b0; i_redirect_pc = '0; i_stall = 1'b0;
  endtask
  task automatic step(input bit stall, input bit redir, input logic [31:0] rpc);
    bit g, rv, st;
    logic [31:0] a, d;
    checks++;
    if (o_imem_req !== m_req) begin errors++; $display("FAIL req cyc=%0d got=%b exp=%b", cyc, o_imem_req, m_req); end
    if (m_req) begin
      checks++;
      if (o_imem_addr !== m_pc) begin errors++; $display("FAIL addr cyc=%0d got=%h exp=%h", cyc, o_imem_addr, m_pc); end
    end
    checks++;
    if (o_en !== m_en) begin errors++; $display("FAIL en cyc=%0d got=%b exp=%b", cyc, o_en, m_en); end
    checks++;
    if ({o_next_pc, o_instr, o_tag} !== {m_npc, m_instr, m_tag_out}) begin
      errors++;
      $display("FAIL out cyc=%0d got=%h/%h/%0d exp=%h/%h/%0d", cyc, o_next_pc, o_instr, o_tag, m_npc, m_instr, m_tag_out);
    end
    g = $urandom_range(99) < gnt_pct;
    rv = f_addr.size() != 0 && f_ready[0] <= cyc && $urandom_range(99) < rv_pct;
    if (o_imem_req === 1'b1 && g) n_dut_gnt++;
    if (o_en === 1'b1) n_dut_en++;
    i_imem_gnt = g; i_imem_rvalid = rv; i_imem_rdata = rv ? f_data[0] : NOP_INSTR;
    i_stall = stall; i_redirect = redir; i_redirect_pc = rpc;
    m_en = q_npc.size() != 0 && !stall && !redir;
    if (m_en) begin
      m_npc = q_npc.pop_front(); m_instr = q_instr.pop_front(); m_tag_out = m_tag; m_tag++;
    end
    if (rv) begin
      a = f_addr.pop_front(); d = f_data.pop_front(); void'(f_ready.pop_front()); st = f_stale.pop_front();
      if (!st && !redir) begin q_npc.push_back(a + 32'd4); q_instr.push_back(d); end
    end
    if (m_req && g) begin
      f_addr.push_back(m_pc); f_data.push_back(data_is_addr ? m_pc : $urandom);
      f_ready.push_back(cyc + 1); f_stale.push_back(1'b0); m_pc += 32'd4;
    end
    if (redir) begin
      foreach (f_stale[i]) f_stale[i] = 1'b1;
      q_npc.delete(); q_instr.delete(); m_pc = {rpc[31:2], 2'b00};
    end
    m_req = !(f_stale.size() != 0 && f_stale[0]) && q_npc.size() + f_addr.size() < DEPTH;
    @(posedge i_clk);
    @(negedge i_clk);
    cyc++;
  endtask
  task automatic drain();
    int w = 0;
    gnt_pct = 0; rv_pct = 100;
    while ((f_addr.size() != 0 || q_npc.size() != 0 || m_en) && w < 50) begin step(0, 0, 0); w++; end
    checks++;
    if (w >= 50) begin errors++; $display("FAIL drain timeout got=%0d exp<50", w); end
  endtask
  task automatic test_reset();
    idle_inputs(); i_rstn = 1'b0; reset_model();
    repeat (2) @(negedge i_clk);
    checks++;
    if ({o_imem_req, o_en, o_next_pc, o_instr, o_tag} !== '0) begin
      errors++; $display("FAIL reset_outs got=%b/%b/%h/%h/%0d exp=all zero", o_imem_req, o_en, o_next_pc, o_instr, o_tag);
    end
    i_rstn = 1'b1;
    #1;
  endtask
  task automatic test_stream();
    gnt_pct = 100; rv_pct = 100; data_is_addr = 1'b1;
    repeat (3) step(0, 0, 0);
    checks += 4;
    if (o_en !== 1'b1) begin errors++; $display("FAIL first_en got=%b exp=1", o_en); end
    if (o_instr !== 32'h0) begin errors++; $display("FAIL first_instr got=%h exp=0", o_instr); end
    if (o_next_pc !== 32'h4) begin errors++; $display("FAIL first_npc got=%h exp=4", o_next_pc); end
    if (o_tag !== '0) begin errors++; $display("FAIL first_tag got=%0d exp=0", o_tag); end
    repeat (20) step(0, 0, 0);
    data_is_addr = 1'b0;
  endtask
  task automatic test_stall();
    int g0, e0;
    drain();
    gnt_pct = 100; rv_pct = 100; g0 = n_dut_gnt;
    repeat (10) step(1, 0, 0);
    checks += 2;
    if (n_dut_gnt - g0 !== DEPTH) begin errors++; $display("FAIL stall_grants got=%0d exp=%0d", n_dut_gnt - g0, DEPTH); end
    if (o_imem_req !== 1'b0) begin errors++; $display("FAIL stall_req got=%b exp=0", o_imem_req); end
    e0 = n_dut_en;
    repeat (5) step(0, 0, 0);
    checks++;
    if (n_dut_en - e0 !== 4) begin errors++; $display("FAIL stall_release_en got=%0d exp=4", n_dut_en - e0); end
    repeat (5) step(0, 0, 0);
  endtask
  task automatic test_redirect();
    int w = 0;
    drain();
    gnt_pct = 100; rv_pct = 0;
    repeat (3) step(0, 0, 0);
    gnt_pct = 0;
    step(0, 1, 32'h0000_0103);
    gnt_pct = 100; rv_pct = 100;
    while (o_imem_req !== 1'b1 && w < 20) begin step(0, 0, 0); w++; end
    checks += 2;
    if (w != 3) begin errors++; $display("FAIL redirect_quiet got=%0d exp=3", w); end
    if (o_imem_addr !== 32'h0000_0100) begin errors++; $display("FAIL redirect_addr got=%h exp=00000100", o_imem_addr); end
    repeat (8) step(0, 0, 0);
  endtask
  task automatic test_back_to_back();
    gnt_pct = 100; rv_pct = 100;
    repeat (25) begin
      repeat ($urandom_range(1, 4)) step(0, 0, 0);
      step(0, 1, $urandom);
    end
    repeat (6) step(0, 0, 0);
  endtask
  task automatic test_random();
    repeat (1500) begin
      gnt_pct = $urandom_range(30, 100); rv_pct = $urandom_range(30, 100);
      step($urandom_range(99) < 20, $urandom_range(99) < 3, $urandom);
    end
  endtask
  task automatic test_async_reset();
    gnt_pct = 100; rv_pct = 100;
    repeat (10) step(1, 0, 0);
    idle_inputs(); i_rstn = 1'b0;
    #1;
    checks++;
    if ({o_imem_req, o_en, o_next_pc, o_instr, o_tag} !== '0) begin
      errors++; $display("FAIL async_reset got=%b/%b/%h/%h/%0d exp=all zero", o_imem_req, o_en, o_next_pc, o_instr, o_tag);
    end
    reset_model();
    @(posedge i_clk);
    @(negedge i_clk);
    i_rstn = 1'b1;
    #1;
    checks++;
    if (o_imem_req !== 1'b1 || o_imem_addr !== RESET_PC) begin
      errors++; $display("FAIL post_reset_req got=%b/%h exp=1/%h", o_imem_req, o_imem_addr, RESET_PC);
    end
    repeat (10) step(0, 0, 0);
  endtask
  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_back_to_back();
    test_random();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
